scan_doubler: RTL
=================

# scan_doubler

Line-doubling video output stage placed directly downstream of the VIC6569 in gm64. It buffers each incoming 12-bit RGB444 line, arriving at half the clock rate, and emits that line twice at full clock rate. This converts 15.6 kHz PAL line timing to 31 kHz VGA timing for the o_hsync/o_vsync/o_red/o_green/o_blue board pins. It can optionally dim every second output line (scanline effect).

## Interface
- MAX_PIX, 512: line buffer depth per bank, in pixels
- ADDR_W, 9: pointer width; must satisfy 2^ADDR_W ≥ MAX_PIX
- HS_LEN, 48: output hsync pulse width, in clk cycles
- clk  in  1  video clock (clkVideo); all logic on rising edge
- reset  in  1  asynchronous, active-low; resets all state
- i_pix_en  in  1  input pixel strobe; nominally every 2nd clk
- i_hsync  in  1  input hsync, active-low
- i_vsync  in  1  input vsync, active-low
- i_red / i_green / i_blue  in  4 each  input pixel, sampled when i_pix_en=1
- i_scanlines  in  1  1 = dim the second copy of each line
- o_hsync  out  1  output hsync, active-low
- o_vsync  out  1  output vsync, active-low
- o_red / o_green / o_blue  out  4 each  output pixel, registered

## Operation
- Ping-pong buffer of two banks, each MAX_PIX × 12 bit.
  - wbank receives the current input line.
  - rbank (= !wbank) holds the previous input line.
- Write side:
  - Each i_pix_en: write {r,g,b} to buf[wbank][wptr], then increment wptr.
  - wptr saturates at MAX_PIX. Pixels beyond MAX_PIX are dropped.
- Line edge:
  - i_hsync is registered every clk.
  - A falling edge (previous 1, current 0) defines the line boundary.
  - At the edge: latch line_len = wptr; clear wptr; toggle wbank; latch vs_line = i_vsync; start the output FSM.
- Output FSM states: IDLE, LINE0, LINE1.
  - Any line edge, in any state, enters LINE0 with rptr=0 and the new rbank, provided line_len ≠ 0. This aborts any output line in progress.
  - line_len = 0: stay in or go to IDLE. The bank toggle still occurs.
  - LINE0 → LINE1 after line_len cycles; rptr restarts at 0.
  - LINE1 → IDLE after line_len cycles.
  - rptr increments every clk in LINE0/LINE1.
- Output generation:
  - o_hsync = 0 for the first HS_LEN cycles of each LINE0 and each LINE1; otherwise 1.
  - RGB = 0 while o_hsync=0 and in IDLE; otherwise buf[rbank][rptr].
  - In LINE1 with i_scanlines=1, each channel is shifted right by 1. i_scanlines is sampled at LINE1 entry.
- Vsync: o_vsync = vs_line, updated at each LINE0 entry. Vsync is therefore quantised to input line boundaries and delayed by one input line.
- Width rule: line_len is ADDR_W+1 bits so that it can represent MAX_PIX.

## Timing
- Reset values: o_hsync=1, o_vsync=1, RGB=0, FSM=IDLE, wbank=0, wptr=0, rptr=0, line_len=0, vs_line=1.
- Reset asserted mid-line returns to reset values immediately. Buffer contents are don't-care.
- Edge detected in cycle T (registered i_hsync low, previous high):
  - o_hsync goes low at T+1.
  - Pixel j of LINE0 is driven at T+1+j. This includes 1 cycle of synchronous-read RAM latency.
  - LINE1 pixel j is driven at T+1+line_len+j.
  - Return to IDLE at T+1+2·line_len.
- Same-cycle i_pix_en and line edge: the pixel is written to the old bank at the old wptr, and is included in line_len.
- If i_pix_en is faster than every 2nd clk, LINE1 is truncated by the next edge. This is defined behaviour, not an error.

## Structure
- Shared include header gm64_video.vh (with include guard) holds the RGB444 width (12) and the sync polarity constant (active-low). The VIC6569 uses the same header.
- Sub-module line_buffer_dp: simple dual-port RAM, depth 2·MAX_PIX, 12-bit data, registered read. Written to infer GateMate block RAM.
- The FSM, pointers and sync logic live in scan_doubler.

## Test plan
- Reset released, no stimulus → o_hsync=1, o_vsync=1, RGB=0 indefinitely.
- Line of 400 pixels at every-2nd-clk with value = index, then hsync edge at T:
  - o_hsync low during T+1..T+48.
  - o_red/green/blue = pixel 48 at T+49.
  - The same sequence repeats starting T+401.
  - IDLE (RGB=0) from T+801.
- Same line with i_scanlines=1, input 0xFFF → LINE0 outputs 0xFFF; LINE1 outputs 0x777.
- 600 pixels with MAX_PIX=512 → line_len=512; the output line lasts 512 cycles; pixels 512–599 are never output.
- i_vsync low during input line k → o_vsync low starting at the LINE0 of line k+1's edge, for exactly two output lines per input line held low.
- Reset pulsed low mid-LINE1 → outputs return to reset values within the same cycle. A new edge then restarts cleanly with wbank=0.

Source files
------------

// File: rtl/scan_doubler_pkg.sv
// Shared constants, FSM state type and pixel helpers for the line-doubling video stage.
// The RGB444 width and sync polarity are common to the whole gm64 video path.
package scan_doubler_pkg;

    localparam int   RGB_W       = 12;
    localparam logic SYNC_ACTIVE = 1'b0;

    localparam int DEF_MAX_PIX = 512;
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_HS_LEN  = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LINE0 = 2'd1,
        ST_LINE1 = 2'd2
    } out_state_t;

    // Scanline effect: halve every 4-bit channel independently.
    function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0] p);
        return {1'b0, p[11:9], 1'b0, p[7:5], 1'b0, p[3:1]};
    endfunction

endpackage

// File: rtl/scan_doubler_if.sv
// Video bus between the VIC6569 side (slow input line) and the VGA pins (doubled output).
// master drives the input pixels and observes the output; slave is the scan doubler.
interface scan_doubler_if;

    logic       i_pix_en;
    logic       i_hsync;
    logic       i_vsync;
    logic [3:0] i_red;
    logic [3:0] i_green;
    logic [3:0] i_blue;
    logic       i_scanlines;

    logic       o_hsync;
    logic       o_vsync;
    logic [3:0] o_red;
    logic [3:0] o_green;
    logic [3:0] o_blue;

    modport master (
        output i_pix_en, i_hsync, i_vsync, i_red, i_green, i_blue, i_scanlines,
        input  o_hsync, o_vsync, o_red, o_green, o_blue
    );

    modport slave (
        input  i_pix_en, i_hsync, i_vsync, i_red, i_green, i_blue, i_scanlines,
        output o_hsync, o_vsync, o_red, o_green, o_blue
    );

endinterface

// File: rtl/line_buffer_dp.sv
// Simple dual-port line RAM with registered read, shaped for GateMate block RAM inference.
// No reset on the array or read register so the tools can map it to a BRAM primitive.
module line_buffer_dp #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/scan_doubler.sv
// Line doubler: buffers each half-rate input line in a ping-pong RAM and replays it twice
// at full clock rate, with optional dimming of the second copy.
//
//   state    | meaning
//   ST_IDLE  | no line to show; hsync high, RGB black
//   ST_LINE0 | first replay of the previous input line
//   ST_LINE1 | second replay, optionally dimmed
module scan_doubler
    import scan_doubler_pkg::*;
#(
    parameter int MAX_PIX = DEF_MAX_PIX,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int HS_LEN  = DEF_HS_LEN
) (
    input logic           clk,
    input logic           reset,
    scan_doubler_if.slave vid
);

    localparam int               LEN_W   = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PIX);
    localparam logic [LEN_W-1:0] HS_CNT  = LEN_W'(HS_LEN);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    out_state_t       state, state_nxt;
    logic [LEN_W-1:0] rptr, rptr_nxt;
    logic [LEN_W-1:0] wptr, wptr_eff, line_len;
    logic             scan_q, scan_nxt;
    logic             wbank, rd_bank;
    logic             hs_q, hs_q2, line_edge;
    logic             wr_en, new_len_ok;
    logic             vs_line, vs_out, hs_out;
    logic             hs_low_nxt, rgb_en, dim;
    logic [RGB_W-1:0] rd_data, pix;

    assign line_edge  = hs_q2 & ~hs_q;
    assign wr_en      = vid.i_pix_en && (wptr != MAX_LEN);
    assign wptr_eff   = wr_en ? wptr + ONE : wptr;
    assign new_len_ok = (wptr_eff != '0);
    // The bank just written becomes the read bank on the edge cycle itself.
    assign rd_bank    = line_edge ? wbank : ~wbank;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            rptr   <= '0;
            scan_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            rptr   <= rptr_nxt;
            scan_q <= scan_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rptr_nxt  = rptr;
        scan_nxt  = scan_q;
        if (line_edge) begin
            rptr_nxt  = '0;
            state_nxt = new_len_ok ? ST_LINE0 : ST_IDLE;
        end else begin
            case (state)
                ST_LINE0: begin
                    if (rptr == line_len - ONE) begin
                        state_nxt = ST_LINE1;
                        rptr_nxt  = '0;
                        scan_nxt  = vid.i_scanlines;
                    end else begin
                        rptr_nxt = rptr + ONE;
                    end
                end
                ST_LINE1: begin
                    if (rptr == line_len - ONE) begin
                        state_nxt = ST_IDLE;
                        rptr_nxt  = '0;
                    end else begin
                        rptr_nxt = rptr + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hs_low_nxt = (state_nxt != ST_IDLE) && (rptr_nxt < HS_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q     <= ~SYNC_ACTIVE;
            hs_q2    <= ~SYNC_ACTIVE;
            wptr     <= '0;
            wbank    <= 1'b0;
            line_len <= '0;
            vs_line  <= ~SYNC_ACTIVE;
            vs_out   <= ~SYNC_ACTIVE;
            hs_out   <= ~SYNC_ACTIVE;
            rgb_en   <= 1'b0;
            dim      <= 1'b0;
        end else begin
            hs_q  <= vid.i_hsync;
            hs_q2 <= hs_q;
            if (line_edge) begin
                line_len <= wptr_eff;
                wptr     <= '0;
                wbank    <= ~wbank;
                vs_line  <= vid.i_vsync;
                // vsync follows the line that was latched one edge earlier
                if (new_len_ok) begin
                    vs_out <= vs_line;
                end
            end else begin
                wptr <= wptr_eff;
            end
            hs_out <= hs_low_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            rgb_en <= (state_nxt != ST_IDLE) && !hs_low_nxt;
            dim    <= (state_nxt == ST_LINE1) && scan_nxt;
        end
    end

    line_buffer_dp #(
        .DEPTH (2 ** LEN_W),
        .AW    (LEN_W),
        .DW    (RGB_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wbank, wptr[ADDR_W-1:0]}),
        .wdata ({vid.i_red, vid.i_green, vid.i_blue}),
        .raddr ({rd_bank, rptr_nxt[ADDR_W-1:0]}),
        .rdata (rd_data)
    );

    assign pix = dim ? dim_rgb(rd_data) : rd_data;

    assign vid.o_hsync = hs_out;
    assign vid.o_vsync = vs_out;
    assign {vid.o_red, vid.o_green, vid.o_blue} = rgb_en ? pix : '0;

endmodule
